// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer
// Command-path controller for the SD host. Takes one command at a time,
// packs it into the serial command host's setting/command words, runs the
// REQ/ACK handshake with that block (acknowledging every status phase),
// captures the response, checks CRC/index, enforces a timeout and reports
// completion as a single done pulse with error flags.
//
// Ports
//   SD_CLK_IN, RST_IN        : clock, synchronous active-low reset
//   start_i                  : one-cycle start, ignored while busy_o=1
//   cmd_index_i, cmd_arg_i   : command index / argument
//   rsp_type_i               : 00 none, 01 short, 10 long, 11 as 01
//   crc_chk_i, idx_chk_i     : response CRC / index check enables
//   wo_dly_i                 : post-write delay for no-response commands
//   blk_wr_i, blk_rd_i       : data-path start flags (passed through)
//   word_sel_i               : long-response word select
//   timeout_i                : timeout in clocks, 0 disables
//   busy_o, done_o, err_o    : status; err_o = {proto, index, crc, timeout}
//   rsp_o                    : captured response
//   host_setting_o/cmd_o/req_o, host_ack_i : command side of serial host
//   host_req_i/status_i/rsp_i, host_ack_o  : status side of serial host
//   host_srst_o              : active-high reset to the serial host
module sd_cmd_sequencer #(
    parameter int unsigned TMO_W    = 16,
    parameter int unsigned SRST_CYC = 2
) (
    input  logic             SD_CLK_IN,
    input  logic             RST_IN,
    input  logic             start_i,
    input  logic [5:0]       cmd_index_i,
    input  logic [31:0]      cmd_arg_i,
    input  logic [1:0]       rsp_type_i,
    input  logic             crc_chk_i,
    input  logic             idx_chk_i,
    input  logic [2:0]       wo_dly_i,
    input  logic             blk_wr_i,
    input  logic             blk_rd_i,
    input  logic [1:0]       word_sel_i,
    input  logic [TMO_W-1:0] timeout_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [3:0]       err_o,
    output logic [39:0]      rsp_o,
    output logic [15:0]      host_setting_o,
    output logic [39:0]      host_cmd_o,
    output logic             host_req_o,
    input  logic             host_ack_i,
    input  logic             host_req_i,
    input  logic [7:0]       host_status_i,
    input  logic [39:0]      host_rsp_i,
    output logic             host_ack_o,
    output logic             host_srst_o
);

    localparam int unsigned SRST_W = (SRST_CYC > 1) ? $clog2(SRST_CYC) : 1;
    localparam logic [SRST_W-1:0] SRST_LAST = SRST_W'(SRST_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RUN,
        ST_FINISH,
        ST_ABORT,
        ST_DONE
    } state_t;

    state_t            state;
    logic              req_prev;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [SRST_W-1:0] srst_cnt;
    logic              crc_ok_q;
    logic              crc_eff_q;
    logic              idx_chk_q;
    logic              rsp_short_q;

    logic              capture;
    logic [3:0]        code;
    logic              code_ok;
    logic              tmo_hit;
    logic              accept;
    logic [6:0]        rsp_len;
    logic              crc_eff_d;
    logic [15:0]       setting_d;
    logic              idx_err;

    // Status bits other than the code and CRC-ok flag carry nothing we act on.
    logic unused_status;
    assign unused_status = ^{host_status_i[7:6], host_status_i[4]};

    always_comb begin
        capture   = host_req_i & ~req_prev;
        code      = host_status_i[3:0];
        code_ok   = (code != 4'd0) && (code <= 4'd6);
        tmo_hit   = (timeout_i != '0) && (tmo_cnt == timeout_i);
        // DONE already has busy_o low, so a start there is taken immediately.
        accept    = start_i && ((state == ST_IDLE) || (state == ST_DONE));
        case (rsp_type_i)
            2'b00:   rsp_len = 7'd0;
            2'b10:   rsp_len = 7'd127;
            default: rsp_len = 7'd40;
        endcase
        crc_eff_d = crc_chk_i & (rsp_type_i != 2'b10);
        setting_d = {1'b0, word_sel_i, blk_rd_i, blk_wr_i, wo_dly_i, crc_eff_d, rsp_len};
        idx_err   = idx_chk_q & rsp_short_q & (rsp_o[37:32] != host_cmd_o[37:32]);
    end

    always_ff @(posedge SD_CLK_IN) begin
        if (!RST_IN) begin
            state          <= ST_IDLE;
            req_prev       <= 1'b0;
            tmo_cnt        <= '0;
            srst_cnt       <= '0;
            crc_ok_q       <= 1'b0;
            crc_eff_q      <= 1'b0;
            idx_chk_q      <= 1'b0;
            rsp_short_q    <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= '0;
            rsp_o          <= '0;
            host_setting_o <= '0;
            host_cmd_o     <= '0;
            host_req_o     <= 1'b0;
            host_ack_o     <= 1'b0;
            host_srst_o    <= 1'b0;
        end else begin
            req_prev <= host_req_i;
            done_o   <= 1'b0;

            if (accept) begin
                state          <= ST_REQ;
                busy_o         <= 1'b1;
                host_req_o     <= 1'b1;
                host_ack_o     <= 1'b0;
                tmo_cnt        <= '0;
                err_o          <= '0;
                rsp_o          <= '0;
                host_cmd_o     <= {2'b01, cmd_index_i, cmd_arg_i};
                host_setting_o <= setting_d;
                crc_eff_q      <= crc_eff_d;
                idx_chk_q      <= idx_chk_i;
                rsp_short_q    <= rsp_type_i[0];
            end else begin
                case (state)
                    ST_REQ, ST_RUN, ST_FINISH: begin
                        // Timeout is checked first so it wins over a final
                        // capture or a FINISH exit in the same cycle.
                        if (tmo_hit) begin
                            err_o[0]    <= 1'b1;
                            state       <= ST_ABORT;
                            host_srst_o <= 1'b1;
                            srst_cnt    <= '0;
                            host_req_o  <= 1'b0;
                            host_ack_o  <= 1'b0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                            if (state == ST_FINISH) begin
                                if (host_ack_i && !host_req_i) begin
                                    host_ack_o <= 1'b0;
                                    err_o[1]   <= crc_eff_q & ~crc_ok_q;
                                    err_o[2]   <= idx_err;
                                    state      <= ST_DONE;
                                    done_o     <= 1'b1;
                                    busy_o     <= 1'b0;
                                end
                            end else if (capture) begin
                                crc_ok_q <= host_status_i[5];
                                if (!code_ok) begin
                                    err_o[3]    <= 1'b1;
                                    state       <= ST_ABORT;
                                    host_srst_o <= 1'b1;
                                    srst_cnt    <= '0;
                                    host_req_o  <= 1'b0;
                                    host_ack_o  <= 1'b0;
                                end else begin
                                    host_ack_o <= 1'b1;
                                    if (state == ST_REQ) begin
                                        if ((code == 4'd1) || (code == 4'd2)) begin
                                            host_req_o <= 1'b0;
                                            state      <= ST_RUN;
                                        end
                                    end else if (code == 4'd4) begin
                                        state <= ST_FINISH;
                                    end else if (code == 4'd6) begin
                                        rsp_o <= host_rsp_i;
                                        state <= ST_FINISH;
                                    end
                                end
                            end else if (host_ack_o && !host_req_i) begin
                                host_ack_o <= 1'b0;
                            end
                        end
                    end

                    ST_ABORT: begin
                        if (host_srst_o) begin
                            if (srst_cnt == SRST_LAST) begin
                                host_srst_o <= 1'b0;
                            end else begin
                                srst_cnt <= srst_cnt + 1'b1;
                            end
                        end else if (host_ack_i) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                        end
                    end

                    ST_DONE: begin
                        state <= ST_IDLE;
                    end

                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
